// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
//
// Sits between the CPU memory stage and a word-block main memory. Hits
// retire in the same cycle; misses raise BUSYWAIT while an optional dirty
// victim is written back and the missing block is refilled.
//
// Ports:
//   CLK, RESET             clock (rising edge), async active-low reset
//   READ, WRITE            CPU load / store request (both high = store)
//   ADDRESS, WRITEDATA     byte address and store data
//   READDATA, BUSYWAIT     load data and stall back to the CPU
//   mem_read, mem_write    registered block read / write requests
//   mem_address            28-bit block address
//   mem_writedata          victim block, word 0 in [31:0]
//   mem_readdata           refill block, same packing
//   mem_busywait           main memory busy with the current request
//
// Optional feature: define DCACHE_STATS_EN to add miss_count and
// writeback_count outputs (free-running, wrap at 2^32).
module data_cache #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  miss_count,
    output logic [31:0]  writeback_count
`endif
);

    localparam int NUM_BLOCKS = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                 state;
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [NUM_BLOCKS-1:0]  dirty_q;
    logic [TAG_BITS-1:0]    tag_mem  [NUM_BLOCKS];
    logic [3:0][31:0]       data_mem [NUM_BLOCKS];
    logic [3:0][31:0]       fill_buf;
    logic [31:0]            rd_hold;

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    addr_tag;
    logic [1:0]             offset;
    logic                   access;
    logic                   hit;
    logic                   in_idle;
    logic                   rd_hit;
    logic                   wr_hit;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   unused_addr_bits;

    assign idx      = ADDRESS[4 +: INDEX_BITS];
    assign addr_tag = ADDRESS[31 -: TAG_BITS];
    assign offset   = ADDRESS[3:2];
    assign unused_addr_bits = ^ADDRESS[1:0];

    assign access  = READ | WRITE;
    assign hit     = valid_q[idx] && (tag_mem[idx] == addr_tag);
    assign in_idle = (state == IDLE);
    // Simultaneous READ and WRITE is resolved as a store.
    assign rd_hit  = in_idle && hit && READ && !WRITE;
    assign wr_hit  = in_idle && hit && WRITE;

    // Gated by RESET so the stall drops together with an aborted miss.
    assign BUSYWAIT = RESET && access && !(in_idle && hit);

    // Load data is combinational on a hit and otherwise holds the last value.
    assign READDATA = rd_hit ? data_mem[idx][offset] : rd_hold;

    // The block being refilled is named by the registered request address,
    // so the install does not depend on the CPU still holding ADDRESS.
    assign fill_idx = mem_address[INDEX_BITS-1:0];
    assign fill_tag = mem_address[27 -: TAG_BITS];

    // Control state: FSM, valid/dirty bits, memory request registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            rd_hold       <= '0;
`ifdef DCACHE_STATS_EN
            miss_count      <= '0;
            writeback_count <= '0;
`endif
        end else begin
            if (rd_hit) rd_hold <= data_mem[idx][offset];
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (WRITE) dirty_q[idx] <= 1'b1;
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tag_mem[idx], idx};
                            mem_writedata <= data_mem[idx];
`ifdef DCACHE_STATS_EN
                            miss_count    <= miss_count + 32'd1;
`endif
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= ADDRESS[31:4];
`ifdef DCACHE_STATS_EN
                            miss_count  <= miss_count + 32'd1;
`endif
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= FETCH;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= ADDRESS[31:4];
`ifdef DCACHE_STATS_EN
                        writeback_count <= writeback_count + 32'd1;
`endif
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid_q[fill_idx] <= 1'b1;
                    dirty_q[fill_idx] <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; their contents are qualified by valid_q.
    // An aborted miss never reaches UPDATE, so no partial block is installed.
    always_ff @(posedge CLK) begin
        if (wr_hit) data_mem[idx][offset] <= WRITEDATA;
        if (state == FETCH && !mem_busywait) fill_buf <= mem_readdata;
        if (state == UPDATE) begin
            data_mem[fill_idx] <= fill_buf;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's memory-stage port and the word-block main data memory. Serves word loads/stores from the pipeline's memory stage; asserts `BUSYWAIT` on misses, which the CPU ORs into its global stall. On a miss it writes back a dirty victim block and refills from main memory with a four-word burst handshake.

## Interface
Parameters:
- `INDEX_BITS`, 3: index width; `2**INDEX_BITS` blocks of 4 words (16 B).
- `TAG_BITS`, `28-INDEX_BITS`: tag width (word address bits above offset and index).

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `READ` in 1: CPU load request.
- `WRITE` in 1: CPU store request.
- `ADDRESS` in 32: byte address. Bits [1:0] ignored, [3:2] word offset, [3+INDEX_BITS:4] index, rest tag.
- `WRITEDATA` in 32: store data.
- `READDATA` out 32: load data.
- `BUSYWAIT` out 1: stall to CPU.
- `mem_read` out 1: main-memory block read request.
- `mem_write` out 1: main-memory block write request.
- `mem_address` out 28: block address (`ADDRESS[31:4]` or victim `{tag,index}`).
- `mem_writedata` out 128: victim block, word 0 in [31:0].
- `mem_readdata` in 128: refill block, same packing.
- `mem_busywait` in 1: high while main memory is busy with the current request.

## Operation
- Storage per block: `valid`, `dirty`, tag, 4×32 data. Reset clears every `valid` and `dirty`; data/tag contents undefined.
- Hit = `valid[index] && tag[index]==ADDRESS tag`.
- `READ`/`WRITE` both high is illegal; treat as `WRITE`.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
  - IDLE: no access, or hit -> stay. Miss with victim clean or invalid -> FETCH. Miss with victim valid and dirty -> WRITEBACK.
  - WRITEBACK: `mem_write=1`, `mem_address={victim tag,index}`, `mem_writedata`=victim block. Exit to FETCH on the first edge sampling `mem_busywait=0`.
  - FETCH: `mem_read=1`, `mem_address=ADDRESS[31:4]`. Exit to UPDATE on the first edge sampling `mem_busywait=0`; `mem_readdata` is captured on that edge.
  - UPDATE: write captured block into data, set tag, `valid=1`, `dirty=0`; -> IDLE. The access then re-evaluates in IDLE as a hit.
- Read hit: `READDATA`=selected word, combinational from the array.
- Write hit: word written and `dirty=1` on the next `CLK` edge; other words unchanged.
- Hits retire in a single cycle, with no extra latency added.
- `BUSYWAIT` = (`READ`|`WRITE`) && !(IDLE && hit). It is combinational and asserts in the cycle the miss is presented.
- `mem_read`/`mem_write` are registered state decodes and are never both high.
- `READDATA` outside a read hit holds its last value (no X propagation); it is 0 after reset.
- `ADDRESS`, `WRITEDATA` and the request lines are held by the CPU while `BUSYWAIT=1`. If a request drops mid-miss, the refill still completes, then the FSM idles.

## Timing
- Reset values: `READDATA=0`, `BUSYWAIT=0`, `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_writedata=0`; state IDLE.
- Reset asserted mid-miss aborts at once: memory requests drop asynchronously and no partial block is installed.
- Clean miss with memory latency L cycles (`mem_busywait` high L-1 cycles): `BUSYWAIT` high for L+2 cycles (FETCH L, UPDATE 1, plus the miss-detect cycle). The CPU advances on the edge after `BUSYWAIT` falls.
- Dirty miss: adds the write-back latency L_w cycles before FETCH.
- Same-index conflict: a store to a block just evicted takes the miss path, never a stale hit.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `miss_count` (32 b) and `writeback_count` (32 b).
  - `miss_count` increments on each IDLE->FETCH or IDLE->WRITEBACK transition.
  - `writeback_count` increments on each WRITEBACK->FETCH transition.
  - Both reset to 0 and wrap at 2^32.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- After reset, `READ` at 0x0000_0010 with memory returning 0x44..0x11 words (L=5) -> `BUSYWAIT` high 7 cycles, `mem_address=0x0000001`, then `READDATA=0x11` (word 0), `mem_write` never high.
- Read hit: after the above, `READ` 0x0000_0014 -> `READDATA`=word 1 same cycle, `BUSYWAIT=0`, no memory request.
- Write hit: `WRITE` 0x0000_0018 data 0xDEADBEEF -> no stall; subsequent `READ` 0x18 returns 0xDEADBEEF; block dirty.
- Dirty eviction: `READ` 0x0000_0090 (same index 1, different tag) -> WRITEBACK with `mem_address=0x0000001` and `mem_writedata[95:64]=0xDEADBEEF`, then FETCH with `mem_address=0x0000009`. With `DCACHE_STATS_EN`, `miss_count=2` and `writeback_count=1`.
- Reset during FETCH -> `mem_read` drops without a clock edge, `BUSYWAIT=0`; re-reading the same address misses again.
- `READ`+`WRITE` both high on a hit -> treated as a store; word updated and `dirty=1`.
